layer_sequencer: RTL and testbench
==================================

// Module: layer_sequencer
// PURPOSE
//   FSM sequencing one fully-connected neuron layer built from enable-gated 16-bit
//   registers (input/weight regs, accumulator, output reg). On start: for each neuron,
//   clears the accumulator, streams N_INPUTS addresses to input/weight memories, gates
//   accumulator enable one cycle behind each address, then latches the result.
//   Sits between top-level control and the layer datapath; one instance per layer.
// PARAMETERS
//   DWIDTH     16   datapath width (not used by control; passed down for consistency)
//   N_INPUTS   400  inputs per neuron (1..2**IAWIDTH)
//   N_NEURONS  10   neurons in layer (1..2**NAWIDTH)
//   IAWIDTH    9    input-address width
//   NAWIDTH    4    neuron-index / output-address width
//   WAWIDTH    13   weight-address width (>= clog2(N_INPUTS*N_NEURONS))
// PORTS
//   clk       in   1        clock, rising edge
//   reset     in   1        synchronous, active-high
//   start     in   1        begin layer; sampled only in IDLE
//   stall     in   1        freeze sequencing (memory not ready)
//   busy      out  1        high in any state except IDLE
//   done      out  1        1-cycle pulse in DONE state
//   in_addr   out  IAWIDTH  input memory address
//   w_addr    out  WAWIDTH  weight memory address (running, not multiplied)
//   acc_clr   out  1        accumulator synchronous clear
//   acc_en    out  1        accumulator enable
//   out_en    out  1        output register / result memory write enable
//   out_addr  out  NAWIDTH  current neuron index
// BEHAVIOUR
//   - Reset (any cycle, incl. mid-layer): state=IDLE, all counters 0, all outputs 0.
//   - States: IDLE, CLEAR, ACCUM, DRAIN, WRITE, DONE. Outputs decoded from registers.
//   - IDLE: start=1 -> CLEAR; w_addr, out_addr reset to 0.
//   - CLEAR (1 cyc): acc_clr=1; in_addr=0 -> ACCUM.
//   - ACCUM: issue in_addr/w_addr each unstalled cycle; both +1 after issue;
//     addr_vld flop=1. After address N_INPUTS-1 issued -> DRAIN.
//   - acc_en = addr_vld delayed 1 cycle (memory read latency 1); acc_en=0 when stall.
//   - DRAIN (1 cyc): last acc_en fires -> WRITE.
//   - WRITE (1 cyc): out_en=1, out_addr=neuron idx. If idx==N_NEURONS-1 -> DONE,
//     else idx+1, -> CLEAR. w_addr continues (no reset between neurons).
//   - DONE (1 cyc): done=1 -> IDLE.
//   - stall=1: state, counters, addr_vld pipeline hold; acc_clr/acc_en/out_en forced 0;
//     memories must hold read data while stalled.
//   - start while busy: ignored. start held high across DONE: restarts after IDLE cycle.
//   - Latency start->done (no stall): N_NEURONS*(N_INPUTS+3)+1 cycles.
//   - Counters never wrap within a layer; in_addr max N_INPUTS-1.
// STRUCTURE
//   - Shared package: state encoding localparams (3-bit), memory read-latency constant.
//   - Sub-module: none required; address counters inline. Optional reuse of the team's
//     enable/reset D flip-flop for the addr_vld->acc_en delay stage.
// TESTING  (N_INPUTS=4, N_NEURONS=2; start pulse at cycle 0)
//   - Nominal: acc_clr at 1 and 8; in_addr 0..3 at 2-5, 9-12; acc_en 3-6, 10-13;
//     out_en at 7 (out_addr 0) and 14 (out_addr 1); done at 15; busy 1-15.
//   - w_addr: 0..3 for neuron 0, 4..7 for neuron 1; never resets mid-layer.
//   - stall=1 cycles 3-4: in_addr holds 1, acc_en 0 during stall, sequence shifts +2,
//     done at 17; exactly 8 acc_en pulses total.
//   - start re-pulsed at cycle 5: ignored; only one done pulse.
//   - reset at cycle 10: cycle 11 all outputs 0, busy 0; new start -> full nominal run.
//   - N_NEURONS=1, N_INPUTS=1: acc_clr 1, in_addr 0 at 2, acc_en 3, out_en 4, done 5.

Source files
------------

// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the fully-connected layer sequencer: state encoding and
// the memory read latency that sets the address-to-accumulate delay.
package layer_sequencer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_CLEAR = 3'd1;
  localparam state_t S_ACCUM = 3'd2;
  localparam state_t S_DRAIN = 3'd3;
  localparam state_t S_WRITE = 3'd4;
  localparam state_t S_DONE  = 3'd5;

  // Cycles between presenting an address and its read data being usable.
  localparam int MEM_RD_LAT = 1;

endpackage

// File: rtl/layer_sequencer_dff.sv
// Enable-gated D flip-flop with synchronous active-high clear.
module layer_sequencer_dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk) begin
    if (reset)     q_o <= '0;
    else if (en_i) q_o <= d_i;
  end

endmodule

// File: rtl/layer_sequencer.sv
// Control FSM for one fully-connected layer: per neuron it clears the accumulator,
// streams input/weight addresses, gates accumulate behind the reads and writes the result.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int DWIDTH    = 16,
  parameter int N_INPUTS  = 400,
  parameter int N_NEURONS = 10,
  parameter int IAWIDTH   = 9,
  parameter int NAWIDTH   = 4,
  parameter int WAWIDTH   = 13
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic               stall_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [IAWIDTH-1:0] in_addr_o,
  output logic [WAWIDTH-1:0] w_addr_o,
  output logic               acc_clr_o,
  output logic               acc_en_o,
  output logic               out_en_o,
  output logic [NAWIDTH-1:0] out_addr_o
);

  if (DWIDTH < 1 || N_INPUTS < 1 || N_INPUTS > 2**IAWIDTH ||
      N_NEURONS < 1 || N_NEURONS > 2**NAWIDTH ||
      N_INPUTS * N_NEURONS > 2**WAWIDTH) begin : g_bad_cfg
    $error("layer_sequencer: parameter out of range");
  end

  state_t state_q, state_d;

  logic [IAWIDTH-1:0] in_cnt_q, in_cnt_d;
  logic [WAWIDTH-1:0] w_cnt_q,  w_cnt_d;
  logic [NAWIDTH-1:0] n_cnt_q,  n_cnt_d;
  logic               last_in, last_n;

  assign last_in = (in_cnt_q == IAWIDTH'(N_INPUTS - 1));
  assign last_n  = (n_cnt_q  == NAWIDTH'(N_NEURONS - 1));

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---- next state ----
  always_comb begin
    state_d = state_q;
    if (!stall_i) begin
      case (state_q)
        S_IDLE:  if (start_i) state_d = S_CLEAR;
        S_CLEAR: state_d = S_ACCUM;
        S_ACCUM: if (last_in) state_d = S_DRAIN;
        S_DRAIN: state_d = S_WRITE;
        S_WRITE: state_d = last_n ? S_DONE : S_CLEAR;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---- address / neuron counters ----
  always_comb begin
    in_cnt_d = in_cnt_q;
    w_cnt_d  = w_cnt_q;
    n_cnt_d  = n_cnt_q;
    if (!stall_i) begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            w_cnt_d = '0;
            n_cnt_d = '0;
          end
        end
        S_CLEAR: in_cnt_d = '0;
        S_ACCUM: begin
          // in_addr parks at 0 after the last input; w_addr runs across neurons
          // and stops on the final weight so it never wraps.
          in_cnt_d = last_in ? '0 : in_cnt_q + 1'b1;
          if (!(last_in && last_n)) w_cnt_d = w_cnt_q + 1'b1;
        end
        S_WRITE: if (!last_n) n_cnt_d = n_cnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt_q <= '0;
      w_cnt_q  <= '0;
      n_cnt_q  <= '0;
    end else begin
      in_cnt_q <= in_cnt_d;
      w_cnt_q  <= w_cnt_d;
      n_cnt_q  <= n_cnt_d;
    end
  end

  // ---- address-valid pipeline: accumulate fires MEM_RD_LAT unstalled cycles after issue ----
  logic [MEM_RD_LAT:0] vld_pipe;

  assign vld_pipe[0] = (state_q == S_ACCUM);

  for (genvar k = 1; k <= MEM_RD_LAT; k++) begin : g_vld
    layer_sequencer_dff #(.W(1)) u_vld (
      .clk   (clk),
      .reset (reset),
      .en_i  (!stall_i),
      .d_i   (vld_pipe[k-1]),
      .q_o   (vld_pipe[k])
    );
  end

  // ---- outputs: strobes suppressed while stalled so a frozen state fires nothing ----
  always_comb begin
    busy_o    = (state_q != S_IDLE);
    acc_clr_o = 1'b0;
    acc_en_o  = 1'b0;
    out_en_o  = 1'b0;
    done_o    = 1'b0;
    if (!stall_i) begin
      acc_clr_o = (state_q == S_CLEAR);
      acc_en_o  = vld_pipe[MEM_RD_LAT];
      out_en_o  = (state_q == S_WRITE);
      done_o    = (state_q == S_DONE);
    end
  end

  assign in_addr_o  = in_cnt_q;
  assign w_addr_o   = w_cnt_q;
  assign out_addr_o = n_cnt_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized scoreboard bench for layer_sequencer: two configurations (4x2 and 1x1)
// checked cycle by cycle against a step-index reference model plus a dot-product datapath.
module tb_layer_sequencer;

  localparam int IAW = 9;
  localparam int WAW = 13;
  localparam int NAW = 4;

  typedef struct packed {
    logic           busy;
    logic           clr;
    logic           acc;
    logic           oen;
    logic           dn;
    logic [IAW-1:0] ia;
    logic [WAW-1:0] wa;
    logic [NAW-1:0] oa;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(input bit ok, input string msg);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s", msg);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int NI = (g == 0) ? 4 : 1;
    localparam int NN = (g == 0) ? 2 : 1;
    localparam int L  = NI + 3;
    localparam int K  = NN * L + 1;

    logic           start, stall, reset;
    logic           busy, done, acc_clr, acc_en, out_en;
    logic [IAW-1:0] in_addr;
    logic [WAW-1:0] w_addr;
    logic [NAW-1:0] out_addr;

    layer_sequencer #(
      .DWIDTH(16), .N_INPUTS(NI), .N_NEURONS(NN),
      .IAWIDTH(IAW), .NAWIDTH(NAW), .WAWIDTH(WAW)
    ) dut (
      .clk(clk), .reset(reset), .start_i(start), .stall_i(stall),
      .busy_o(busy), .done_o(done), .in_addr_o(in_addr), .w_addr_o(w_addr),
      .acc_clr_o(acc_clr), .acc_en_o(acc_en), .out_en_o(out_en), .out_addr_o(out_addr)
    );

    obs_t exp_q[$];
    int   res_q[$];
    int   mem_in[NI];
    int   mem_w[NI*NN];
    int   rd_in, rd_w, acc;
    int   cyc = 0;

    // Reference model: busy flag plus index of the current unstalled step of the layer.
    bit             m_busy = 1'b0;
    int             m_s    = 0;
    logic [WAW-1:0] m_idle_w = '0;
    logic [NAW-1:0] m_idle_o = '0;
    bit             flush  = 1'b0;
    bit             fin    = 1'b0;

    function automatic obs_t expect_now(input bit sl);
      obs_t e;
      int n, p;
      e = '0;
      if (!m_busy) begin
        e.wa = m_idle_w;
        e.oa = m_idle_o;
        return e;
      end
      e.busy = 1'b1;
      if (m_s == K) begin
        e.dn = !sl;
        e.wa = WAW'(NI*NN - 1);
        e.oa = NAW'(NN - 1);
        return e;
      end
      n = (m_s - 1) / L;
      p = (m_s - 1) % L;
      e.oa = NAW'(n);
      if (p == 0) begin
        e.clr = !sl;
        e.wa  = WAW'(n*NI);
      end else if (p <= NI) begin
        e.ia  = IAW'(p - 1);
        e.wa  = WAW'(n*NI + p - 1);
        e.acc = (p >= 2) && !sl;
      end else begin
        e.wa = (n == NN-1) ? WAW'(NI*NN - 1) : WAW'((n+1)*NI);
        if (p == NI + 1) e.acc = !sl;
        else             e.oen = !sl;
      end
      return e;
    endfunction

    function automatic void new_run();
      for (int i = 0; i < NI; i++)    mem_in[i] = int'($urandom_range(0, 255));
      for (int i = 0; i < NI*NN; i++) mem_w[i]  = int'($urandom_range(0, 255));
      for (int n = 0; n < NN; n++) begin
        int s = 0;
        for (int i = 0; i < NI; i++) s += mem_in[i] * mem_w[n*NI + i];
        res_q.push_back(s);
      end
    endfunction

    task automatic step(input bit st, input bit sl, input bit rs);
      @(posedge clk);
      #1;
      if (flush) begin
        res_q.delete();
        flush = 1'b0;
      end
      start = st;
      stall = sl;
      reset = rs;
      exp_q.push_back(expect_now(sl));
      if (rs) begin
        m_busy   = 1'b0;
        m_idle_w = '0;
        m_idle_o = '0;
        flush    = 1'b1;
      end else if (!sl) begin
        if (m_busy) begin
          if (m_s == K) begin
            m_busy   = 1'b0;
            m_idle_w = WAW'(NI*NN - 1);
            m_idle_o = NAW'(NN - 1);
          end else begin
            m_s++;
          end
        end else if (st) begin
          m_busy = 1'b1;
          m_s    = 1;
          new_run();
        end
      end
    endtask

    // One layer run; cycle 0 carries the start pulse.
    task automatic run(input int pct, input int re_at, input int rs_at, input bit hold,
                       input int s_lo, input int s_hi);
      int t;
      bit st, sl, rs;
      t = 0;
      do begin
        st = (t == 0) || (t == re_at) || (hold && t <= K + 2);
        sl = (t > 0) && ((t >= s_lo && t <= s_hi) || (int'($urandom_range(0, 99)) < pct));
        rs = (t == rs_at);
        step(st, sl, rs);
        t++;
      end while ((m_busy || (hold && t <= K + 2)) && t < 2000);
      step(1'b0, 1'b0, 1'b0);
    endtask

    // Datapath stand-in: 1-cycle read memories that hold while stalled, and an accumulator.
    always @(posedge clk) begin
      if (!stall) begin
        rd_in <= mem_in[in_addr];
        rd_w  <= mem_w[w_addr];
      end
      if (acc_clr)     acc <= 0;
      else if (acc_en) acc <= acc + rd_in * rd_w;
    end

    always @(negedge clk) begin
      obs_t o, e;
      int   r;
      cyc++;
      if (exp_q.size() != 0) begin
        o = {busy, acc_clr, acc_en, out_en, done, in_addr, w_addr, out_addr};
        e = exp_q.pop_front();
        chk(o === e, $sformatf(
          "cfg%0d cyc%0d outputs: got busy=%b clr=%b acc_en=%b out_en=%b done=%b in=%0d w=%0d out=%0d, expected busy=%b clr=%b acc_en=%b out_en=%b done=%b in=%0d w=%0d out=%0d",
          g, cyc, o.busy, o.clr, o.acc, o.oen, o.dn, o.ia, o.wa, o.oa,
          e.busy, e.clr, e.acc, e.oen, e.dn, e.ia, e.wa, e.oa));
      end
      if (out_en === 1'b1) begin
        if (res_q.size() == 0) begin
          chk(1'b0, $sformatf("cfg%0d cyc%0d result: out_en with no neuron result pending (acc=%0d)",
                              g, cyc, acc));
        end else begin
          r = res_q.pop_front();
          chk(acc == r, $sformatf("cfg%0d cyc%0d result neuron %0d: got %0d, expected %0d",
                                  g, cyc, out_addr, acc, r));
        end
      end
    end

    initial begin
      start = 1'b0;
      stall = 1'b0;
      reset = 1'b1;
      repeat (2) step(1'b0, 1'b0, 1'b1);
      run(0, -1, -1, 1'b0, -1, -1);   // nominal
      run(0, -1, -1, 1'b0,  3,  4);   // stall in cycles 3-4
      run(0,  5, -1, 1'b0, -1, -1);   // start re-pulsed while busy
      run(0, -1, 10, 1'b0, -1, -1);   // reset mid-layer
      run(0, -1, -1, 1'b0, -1, -1);   // clean run after reset
      run(0, -1, -1, 1'b1, -1, -1);   // start held across DONE
      for (int i = 0; i < 10; i++)
        run(int'($urandom_range(10, 40)), int'($urandom_range(1, 12)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 25)) : -1,
            1'b0, -1, -1);
      repeat (3) step(1'b0, 1'b0, 1'b0);
      chk(res_q.size() == 0, $sformatf("cfg%0d results left unwritten: got %0d, expected 0",
                                       g, res_q.size()));
      fin = 1'b1;
    end
  end

  initial begin
    int i;
    i = 0;
    while (!(cfg[0].fin && cfg[1].fin) && i < 50000) begin
      @(posedge clk);
      i++;
    end
    chk(cfg[0].fin && cfg[1].fin,
        $sformatf("drivers finished: got %b%b, expected 11", cfg[1].fin, cfg[0].fin));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
